// File: rtl/ks_sum_stage_if.sv
// rtl/ks_sum_stage_if.sv - handshake and data bundle for the Kogge-Stone sum stage
interface ks_sum_stage_if #(
  parameter int TAG_W = 4
);
  logic             i_valid;
  logic             o_ready;
  logic             i_c0;
  logic [15:0]      i_pk;
  logic [15:0]      i_gk;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [15:0]      o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;

  // Driver side: presents prefix results and consumes sums.
  modport master (
    output i_valid, i_c0, i_pk, i_gk, i_tag, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero, o_tag
  );

  // Stage side: accepts prefix results and presents sums.
  modport slave (
    input  i_valid, i_c0, i_pk, i_gk, i_tag, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero, o_tag
  );
endinterface

// File: rtl/ks_sum_stage.sv
// rtl/ks_sum_stage.sv - sum/flag formation after the last prefix stage, buffered in a two-entry skid
module ks_sum_stage #(
  parameter int TAG_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ks_sum_stage_if.slave bus
);
  // Entry layout: {sum[15:0], cout, ovf, zero, tag}
  localparam int RW = 16 + 3 + TAG_W;

  // Encoding is {skid_v, main_v} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state, state_nxt;
  logic            ready_q;
  logic [RW-1:0]   main_q, skid_q;
  logic [RW-1:0]   result;
  logic [15:0]     sum;
  logic            in_xfer, out_xfer;
  logic            main_load, main_from_skid, skid_load;

  // Bit k of the sum needs the carry into bit k, which is the group generate of bit k-1.
  assign sum[0]    = bus.i_pk[0] ^ bus.i_c0;
  assign sum[15:1] = bus.i_pk[15:1] ^ bus.i_gk[14:0];

  // Overflow is the carry into the sign bit differing from the carry out of it.
  assign result = {sum, bus.i_gk[15], bus.i_gk[15] ^ bus.i_gk[14], ~|sum, bus.i_tag};

  // o_ready is the registered copy, so accepting never depends combinationally on i_ready.
  assign in_xfer  = bus.i_valid & ready_q;
  assign out_xfer = state[0] & bus.i_ready;

  // Next-state and load-enable selection for the skid buffer.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register and registered ready, which tracks whether the skid will be free next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= ~state_nxt[1];
    end
  end

  // Data registers move only on real transfers; skid drains into main ahead of new input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : result;
      end
      if (skid_load) begin
        skid_q <= result;
      end
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = state[0];
  assign bus.o_sum   = main_q[RW-1 -: 16];
  assign bus.o_cout  = main_q[TAG_W+2];
  assign bus.o_ovf   = main_q[TAG_W+1];
  assign bus.o_zero  = main_q[TAG_W];
  assign bus.o_tag   = main_q[TAG_W-1:0];
endmodule
